cpu_bus_arbiter: RTL and testbench
==================================

Name: cpu_bus_arbiter

Overview:
- Parametrised CPU-side bus fabric that replaces the fixed top-level read-data priority mux and the ad-hoc RAM address override.
- Merges NUM_SRC slave read-data sources plus a RAM fallback into the CPU read path.
- Contains a sprite-DMA master: a CPU write to DMA_PAGE_REG stalls the CPU through its ready input and copies DMA_LEN bytes from page N to DMA_DST.
- Sits between the CPU core and the RAM, PPU, APU, joypad and cart slaves.

Parameters:
- NUM_SRC, 4, number of enable-qualified read-data sources; index 0 has the highest priority.
- DATA_W, 8, data bus width.
- ADDR_W, 16, address bus width.
- DMA_PAGE_REG, 16'h4014, write address that triggers DMA.
- DMA_DST, 16'h2004, DMA write target address.
- DMA_LEN, 256, bytes per DMA transfer, 1..256.

Ports:
- bus_clk_in, in, 1, CPU-domain clock.
- bus_rst_n_in, in, 1, asynchronous active-low reset.
- cpu_read_in, in, 1, CPU read strobe.
- cpu_write_in, in, 1, CPU write strobe.
- cpu_address_in, in, ADDR_W, CPU address.
- cpu_data_in, in, DATA_W, CPU write data.
- src_data_en_in, in, NUM_SRC, per-source read-data valid.
- src_data_in, in, NUM_SRC*DATA_W, packed source data; source i occupies [i*DATA_W +: DATA_W].
- ram_data_in, in, DATA_W, RAM read data (fallback).
- cpu_data_out, out, DATA_W, read data to CPU.
- bus_read_out, out, 1, read strobe to slaves.
- bus_write_out, out, 1, write strobe to slaves.
- bus_address_out, out, ADDR_W, address to slaves.
- bus_data_out, out, DATA_W, write data to slaves.
- cpu_rdy_out, out, 1, CPU ready; 0 stalls the CPU.
- dma_busy_out, out, 1, DMA in progress.

Behaviour:
- Clock and reset: single clock bus_clk_in; bus_rst_n_in is asynchronous, active-low.
- Reset values:
  - FSM=IDLE, cpu_rdy_out=1, dma_busy_out=0, parity=0, index=0, page=0, dma_data_q=0.
  - Bus outputs are combinational and follow the CPU inputs in IDLE.
- Read mux (combinational, zero latency): rd_data = src_data of the lowest i with src_data_en_in[i]=1, else ram_data_in. cpu_data_out=rd_data.
- Parity flop: toggles every cycle, free-running. parity=1 marks an odd cycle.
- FSM states: IDLE, HALT, ALIGN, RD, WR.
- IDLE:
  - bus_* = cpu_*.
  - Trigger condition: cpu_write_in=1 and cpu_address_in==DMA_PAGE_REG.
  - On trigger: latch page=cpu_data_in, go to HALT next cycle. The trigger write itself is still forwarded to the slaves.
- HALT (1 cycle): cpu_rdy_out=0, bus strobes 0. Next state: ALIGN if parity==1 in this cycle, else RD.
- ALIGN (1 cycle): strobes 0, next state RD.
- RD:
  - bus_address_out={page,index[7:0]}, bus_read_out=1.
  - dma_data_q<=rd_data at the clock edge; sources must present data in the same cycle.
  - Next state WR.
- WR:
  - bus_address_out=DMA_DST, bus_write_out=1, bus_data_out=dma_data_q, index++.
  - If index==DMA_LEN-1: go to IDLE with index=0. Else go to RD.
- cpu_rdy_out=0 and dma_busy_out=1 in HALT, ALIGN, RD and WR.
- Total stall: 1+2*DMA_LEN cycles, or 2+2*DMA_LEN with ALIGN. This gives 513/514 cycles at DMA_LEN=256.
- While the FSM is not IDLE:
  - CPU strobes are ignored and not forwarded.
  - A new trigger write is ignored; no retrigger and no page change.
- Index wraps within the page: {page,index[7:0]} never carries into page.
- Reset mid-DMA: immediate IDLE, cpu_rdy_out=1, partial transfer abandoned.
- Simultaneous cpu_read_in and cpu_write_in in IDLE: both are forwarded unchanged. The trigger still fires on the write.

Optional Feature:
- Macro: CPU_BUS_OPEN_BUS_EN.
- With the macro defined:
  - A data_latch register is reset to 0.
  - It loads cpu_data_out on every forwarded CPU read.
  - It loads bus_data_out on every write, CPU or DMA.
  - On a CPU read with no src enable set and address in 16'h4018..16'h5FFF, cpu_data_out=data_latch instead of ram_data_in. This models open bus.
  - DMA RD in that window captures data_latch.
- Without the macro: no latch; that window returns ram_data_in.

Decomposition:
- Package cpu_bus_pkg:
  - FSM state enum.
  - DMA_PAGE_REG/DMA_DST defaults.
  - Open-bus window bounds.
- One sub-module, bus_prio_mux: parametrised NUM_SRC/DATA_W first-hit priority mux with RAM fallback. It is reused for the PPU-side CHR/VRAM mux.

Test Plan:
- Priority: en=4'b0110 with src1=8'hA1, src2=8'hB2 -> cpu_data_out=8'hA1. en=0 -> ram_data_in.
- DMA even start: write 8'h02 to 16'h4014 with parity=0 in HALT -> rdy low 513 cycles. 256 RD at 16'h0200..16'h02FF, 256 WR to 16'h2004 carrying the RAM bytes in order.
- DMA odd start: same trigger with parity=1 in HALT -> one ALIGN cycle, 514-cycle stall, same data sequence.
- Retrigger/ignore: CPU write 8'h07 to 16'h4014 mid-DMA -> not forwarded, page stays 8'h02, length unchanged.
- Reset mid-DMA: assert bus_rst_n_in at WR #100 -> cpu_rdy_out=1 and dma_busy_out=0 immediately. A new trigger after reset starts again at index 0.
- CPU_BUS_OPEN_BUS_EN: read from 16'h2002 returns 8'h5C, then read from 16'h4020 with no en set -> 8'h5C. Without the macro -> ram_data_in.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// ---------------------------------------------------------------------------
// cpu_bus_pkg
// Shared types and constants for the CPU-side bus fabric:
//   - dma_state_e      : sprite-DMA controller states
//   - DMA_*_DEF        : default trigger / target addresses and length
//   - OPEN_BUS_LO/HI   : address window that floats (open bus) when no
//                        slave claims a read
//   - in_open_bus()    : window membership helper
// ---------------------------------------------------------------------------
package cpu_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HALT,
        ST_ALIGN,
        ST_RD,
        ST_WR
    } dma_state_e;

    localparam logic [15:0] DMA_PAGE_REG_DEF = 16'h4014;
    localparam logic [15:0] DMA_DST_DEF      = 16'h2004;
    localparam int          DMA_LEN_DEF      = 256;

    localparam logic [15:0] OPEN_BUS_LO = 16'h4018;
    localparam logic [15:0] OPEN_BUS_HI = 16'h5FFF;

    function automatic logic in_open_bus(input logic [15:0] addr);
        return (addr >= OPEN_BUS_LO) && (addr <= OPEN_BUS_HI);
    endfunction

endpackage

// File: rtl/bus_prio_mux.sv
// ---------------------------------------------------------------------------
// bus_prio_mux
// First-hit priority read-data mux with a fallback source. The lowest-index
// enabled source wins; with no source enabled the fallback passes through.
// Used for the CPU read path and for the PPU-side CHR/VRAM mux.
//
// Ports:
//   src_en        in  NUM_SRC         per-source data valid
//   src_data      in  NUM_SRC*DATA_W  packed data, source i at [i*DATA_W +: DATA_W]
//   fallback_data in  DATA_W          data used when no source is enabled
//   mux_data      out DATA_W          selected data
// ---------------------------------------------------------------------------
module bus_prio_mux #(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = 8
) (
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [DATA_W-1:0]         fallback_data,
    output logic [DATA_W-1:0]         mux_data
);

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block leaves it unassigned (no latch).
        mux_data = fallback_data;
        // Scan from the lowest priority upward so the lowest enabled index
        // is the last assignment and therefore wins.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (src_en[i]) begin
                mux_data = src_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_bus_arbiter
// CPU-side bus fabric: merges NUM_SRC slave read-data sources plus a RAM
// fallback into the CPU read path, and hosts the sprite-DMA master. A CPU
// write to DMA_PAGE_REG stalls the CPU (cpu_rdy_out=0) while DMA_LEN bytes
// are copied from page N (the written value) to DMA_DST, one read/write pair
// per byte. An extra ALIGN cycle is inserted when the stall begins on an odd
// cycle of the free-running parity flop.
//
// Optional feature (macro CPU_BUS_OPEN_BUS_EN): a data latch remembers the
// last value seen on the bus; unclaimed reads in the open-bus window return
// it instead of RAM data.
//
// Ports:
//   bus_clk_in       in  1               CPU-domain clock
//   bus_rst_n_in     in  1               async active-low reset
//   cpu_read_in      in  1               CPU read strobe
//   cpu_write_in     in  1               CPU write strobe
//   cpu_address_in   in  ADDR_W          CPU address
//   cpu_data_in      in  DATA_W          CPU write data
//   src_data_en_in   in  NUM_SRC         per-source read-data valid
//   src_data_in      in  NUM_SRC*DATA_W  packed source read data
//   ram_data_in      in  DATA_W          RAM read data (fallback)
//   cpu_data_out     out DATA_W          read data to CPU
//   bus_read_out     out 1               read strobe to slaves
//   bus_write_out    out 1               write strobe to slaves
//   bus_address_out  out ADDR_W          address to slaves
//   bus_data_out     out DATA_W          write data to slaves
//   cpu_rdy_out      out 1               CPU ready, 0 stalls the CPU
//   dma_busy_out     out 1               DMA in progress
// ---------------------------------------------------------------------------
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int                NUM_SRC      = 4,
    parameter int                DATA_W       = 8,
    parameter int                ADDR_W       = 16,
    parameter logic [ADDR_W-1:0] DMA_PAGE_REG = ADDR_W'(DMA_PAGE_REG_DEF),
    parameter logic [ADDR_W-1:0] DMA_DST      = ADDR_W'(DMA_DST_DEF),
    parameter int                DMA_LEN      = DMA_LEN_DEF
) (
    input  logic                      bus_clk_in,
    input  logic                      bus_rst_n_in,
    input  logic                      cpu_read_in,
    input  logic                      cpu_write_in,
    input  logic [ADDR_W-1:0]         cpu_address_in,
    input  logic [DATA_W-1:0]         cpu_data_in,
    input  logic [NUM_SRC-1:0]        src_data_en_in,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_in,
    input  logic [DATA_W-1:0]         ram_data_in,
    output logic [DATA_W-1:0]         cpu_data_out,
    output logic                      bus_read_out,
    output logic                      bus_write_out,
    output logic [ADDR_W-1:0]         bus_address_out,
    output logic [DATA_W-1:0]         bus_data_out,
    output logic                      cpu_rdy_out,
    output logic                      dma_busy_out
);

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_e        state_q;
    dma_state_e        state_d;
    logic              parity_q;
    logic [DATA_W-1:0] page_q;
    logic [7:0]        index_q;
    logic [DATA_W-1:0] dma_data_q;
    logic [DATA_W-1:0] mux_data;
    logic [DATA_W-1:0] rd_data;
    logic              trigger;

    // Only an IDLE write can start a transfer; writes during a DMA are
    // swallowed and cannot retrigger or change the page.
    assign trigger = (state_q == ST_IDLE) && cpu_write_in &&
                     (cpu_address_in == DMA_PAGE_REG);

    bus_prio_mux #(
        .NUM_SRC (NUM_SRC),
        .DATA_W  (DATA_W)
    ) u_rd_mux (
        .src_en        (src_data_en_in),
        .src_data      (src_data_in),
        .fallback_data (ram_data_in),
        .mux_data      (mux_data)
    );

`ifdef CPU_BUS_OPEN_BUS_EN
    logic [DATA_W-1:0] data_latch_q;
    logic              open_bus_sel;

    // The window check uses the forwarded address, so a CPU read and a
    // DMA RD cycle both see the latch when nobody claims the access.
    assign open_bus_sel = bus_read_out && (src_data_en_in == '0) &&
                          in_open_bus(16'(bus_address_out));
    assign rd_data      = open_bus_sel ? data_latch_q : mux_data;

    always_ff @(posedge bus_clk_in or negedge bus_rst_n_in) begin
        if (!bus_rst_n_in) begin
            data_latch_q <= '0;
        end else if (bus_write_out) begin
            data_latch_q <= bus_data_out;
        end else if ((state_q == ST_IDLE) && bus_read_out) begin
            data_latch_q <= rd_data;
        end
    end
`else
    assign rd_data = mux_data;
`endif

    assign cpu_data_out = rd_data;
    assign cpu_rdy_out  = (state_q == ST_IDLE);
    assign dma_busy_out = (state_q != ST_IDLE);

    // Next-state and bus outputs.
    always_comb begin
        state_d         = state_q;
        bus_read_out    = 1'b0;
        bus_write_out   = 1'b0;
        bus_address_out = cpu_address_in;
        bus_data_out    = cpu_data_in;
        case (state_q)
            ST_IDLE: begin
                bus_read_out  = cpu_read_in;
                bus_write_out = cpu_write_in;
                if (trigger) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                // Reads must land on even cycles; burn one more if odd.
                state_d = parity_q ? ST_ALIGN : ST_RD;
            end
            ST_ALIGN: begin
                state_d = ST_RD;
            end
            ST_RD: begin
                // Index never carries into the page: it is a pure 8-bit field.
                bus_address_out = ADDR_W'({page_q, index_q});
                bus_read_out    = 1'b1;
                state_d         = ST_WR;
            end
            ST_WR: begin
                bus_address_out = DMA_DST;
                bus_write_out   = 1'b1;
                bus_data_out    = dma_data_q;
                state_d         = (index_q == LAST_IDX) ? ST_IDLE : ST_RD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk_in or negedge bus_rst_n_in) begin
        if (!bus_rst_n_in) begin
            state_q    <= ST_IDLE;
            parity_q   <= 1'b0;
            page_q     <= '0;
            index_q    <= '0;
            dma_data_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples values from before this edge, independent of
            // statement order.
            state_q  <= state_d;
            parity_q <= ~parity_q;
            if (trigger) begin
                page_q <= cpu_data_in;
            end
            if (state_q == ST_RD) begin
                dma_data_q <= rd_data;
            end
            if (state_q == ST_WR) begin
                index_q <= (index_q == LAST_IDX) ? 8'd0 : index_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_bus_arbiter
// Self-checking bench for cpu_bus_arbiter: table-driven read-mux vectors,
// randomized reads against a first-hit reference function, open-bus
// behaviour, and DMA sequences (even/odd start, ignored retrigger, reset
// mid-transfer) compared against a cycle list derived from the transfer
// rules. RAM is a behavioural byte array addressed by bus_address_out.
// ---------------------------------------------------------------------------
module tb_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [3:0]  src_en;
    logic [31:0] src_data;
    logic [7:0]  ram_drv;
    logic        use_mem;
    logic [7:0]  mem [0:65535];
    logic [7:0]  ram_data;

    logic [7:0]  cpu_rdata;
    logic        bus_read;
    logic        bus_write;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        rdy;
    logic        busy;

    int unsigned cyc;
    int          n_cmp = 0;
    int          n_err = 0;

    assign ram_data = use_mem ? mem[bus_addr] : ram_drv;

    cpu_bus_arbiter dut (
        .bus_clk_in      (clk),
        .bus_rst_n_in    (rst_n),
        .cpu_read_in     (cpu_read),
        .cpu_write_in    (cpu_write),
        .cpu_address_in  (cpu_addr),
        .cpu_data_in     (cpu_wdata),
        .src_data_en_in  (src_en),
        .src_data_in     (src_data),
        .ram_data_in     (ram_data),
        .cpu_data_out    (cpu_rdata),
        .bus_read_out    (bus_read),
        .bus_write_out   (bus_write),
        .bus_address_out (bus_addr),
        .bus_data_out    (bus_wdata),
        .cpu_rdy_out     (rdy),
        .dma_busy_out    (busy)
    );

    always #5 clk = ~clk;

    // Cycles since reset release; bit 0 is the expected parity.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: first enabled source from index 0 upward, else RAM.
    function automatic logic [7:0] ref_read(input logic [3:0] en, input logic [31:0] src,
                                            input logic [7:0] ram);
        for (int i = 0; i < 4; i++) begin
            if (en[i]) return src[i*8 +: 8];
        end
        return ram;
    endfunction

    typedef struct {
        logic [3:0]  en;
        logic [31:0] src;
        logic [7:0]  ram;
        logic [15:0] addr;
        logic        rd;
        logic        wr;
        logic [7:0]  exp;
    } vec_t;

    // One DMA run. want_align picks the start parity; inject issues ignored
    // CPU accesses mid-transfer; abort_wr>0 resets right after that WR.
    task automatic run_dma(input logic [7:0] page, input bit want_align,
                           input bit inject, input int abort_wr);
        int  stall_exp;
        int  pre;
        int  cycles = 0;
        int  errs = 0;
        int  nwr = 0;
        bit  done = 0;
        bit  aborted = 0;
        logic        e_rd, e_wr;
        logic [15:0] e_addr;
        logic [7:0]  e_data;

        pre       = want_align ? 2 : 1;
        stall_exp = pre + 2 * 256;
        use_mem   = 1'b1;
        src_en    = '0;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        // Align so that the HALT cycle has the wanted parity.
        for (int t = 0; t < 2; t++) begin
            @(negedge clk);
            if ((cyc[0] == 1'b0) == want_align) break;
        end
        cpu_write = 1'b1;
        cpu_addr  = 16'h4014;
        cpu_wdata = page;
        #1;
        check("dma_trigger_forwarded", {bus_write, bus_addr, bus_wdata}, {1'b1, 16'h4014, page});

        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            cpu_write = 1'b0;
            cpu_read  = 1'b0;
            if (inject && (i == 0 || i == 50 || i == 51)) begin
                cpu_write = 1'b1;
                cpu_read  = (i == 51);
                cpu_addr  = 16'h4014;
                cpu_wdata = 8'h07;
            end
            #1;
            if (rdy) begin
                done = 1;
                break;
            end
            cycles++;
            e_rd = 0; e_wr = 0; e_addr = '0; e_data = '0;
            if (i >= pre) begin
                e_addr = {page, 8'((i - pre) / 2)};
                if (((i - pre) % 2) == 0) begin
                    e_rd = 1;
                end else begin
                    e_wr   = 1;
                    e_data = mem[e_addr];
                    e_addr = 16'h2004;
                end
            end
            if (bus_read !== e_rd || bus_write !== e_wr || busy !== 1'b1 ||
                ((e_rd || e_wr) && bus_addr !== e_addr) ||
                (e_wr && bus_wdata !== e_data)) begin
                errs++;
            end
            if (bus_write === 1'b1) nwr++;
            if (abort_wr > 0 && nwr == abort_wr) begin
                #1 rst_n = 1'b0;
                #1;
                check("abort_rdy_high", rdy, 1);
                check("abort_busy_low", busy, 0);
                aborted = 1;
                break;
            end
        end
        cpu_write = 1'b0;
        cpu_read  = 1'b0;

        if (aborted) begin
            check("abort_prefix_errs", errs, 0);
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            check("dma_completed", done, 1);
            check("dma_stall_cycles", cycles, stall_exp);
            check("dma_sequence_errs", errs, 0);
            check("dma_end_busy", busy, 0);
        end
    endtask

    initial begin
        vec_t vecs [8];
        logic [7:0] ref_v;

        cpu_read  = 0;
        cpu_write = 0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        src_en    = '0;
        src_data  = '0;
        ram_drv   = '0;
        use_mem   = 0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        vecs[0] = '{4'b0110, 32'h44B2A111, 8'h33, 16'h2002, 1, 0, 8'hA1};
        vecs[1] = '{4'b0000, 32'h44B2A111, 8'h33, 16'h2002, 1, 0, 8'h33};
        vecs[2] = '{4'b1111, 32'h44B2A111, 8'h33, 16'h0100, 1, 0, 8'h11};
        vecs[3] = '{4'b1000, 32'h44B2A111, 8'h33, 16'h4016, 1, 0, 8'h44};
        vecs[4] = '{4'b0100, 32'h44B2A111, 8'h33, 16'h8000, 1, 0, 8'hB2};
        vecs[5] = '{4'b0001, 32'h44B2A111, 8'h5A, 16'hFFFC, 1, 0, 8'h11};
        vecs[6] = '{4'b0000, 32'h44B2A111, 8'h77, 16'h1234, 1, 1, 8'h77};
        vecs[7] = '{4'b1010, 32'h44B2A111, 8'h33, 16'h2007, 1, 0, 8'hA1};

        // Reset state, with IDLE forwarding visible while still in reset.
        repeat (2) @(negedge clk);
        cpu_read = 1;
        cpu_addr = 16'h1111;
        #1;
        check("reset_rdy", rdy, 1);
        check("reset_busy", busy, 0);
        check("reset_fwd_read", {bus_read, bus_write, bus_addr}, {1'b1, 1'b0, 16'h1111});
        cpu_read = 0;
        @(negedge clk);
        rst_n = 1;

        foreach (vecs[k]) begin
            @(negedge clk);
            src_en    = vecs[k].en;
            src_data  = vecs[k].src;
            ram_drv   = vecs[k].ram;
            cpu_addr  = vecs[k].addr;
            cpu_read  = vecs[k].rd;
            cpu_write = vecs[k].wr;
            cpu_wdata = 8'(k * 17 + 3);
            #1;
            check($sformatf("vec%0d_data", k), cpu_rdata, vecs[k].exp);
            check($sformatf("vec%0d_strobes", k), {bus_read, bus_write}, {vecs[k].rd, vecs[k].wr});
            check($sformatf("vec%0d_addr", k), bus_addr, vecs[k].addr);
            check($sformatf("vec%0d_wdata", k), bus_wdata, 8'(k * 17 + 3));
        end
        cpu_write = 0;

        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            src_en   = 4'($urandom);
            src_data = $urandom;
            ram_drv  = 8'($urandom);
            cpu_addr = 16'($urandom);
            if (cpu_addr >= 16'h4018 && cpu_addr <= 16'h5FFF) cpu_addr = cpu_addr & 16'h3FFF;
            cpu_read = 1;
            #1;
            ref_v = ref_read(src_en, src_data, ram_drv);
            check($sformatf("rand%0d_data", n), cpu_rdata, ref_v);
        end

        // Open-bus window read after a claimed read.
        @(negedge clk);
        cpu_read = 1;
        cpu_addr = 16'h2002;
        src_en   = 4'b0010;
        src_data = 32'h0000_5C00;
        ram_drv  = 8'hEE;
        #1;
        check("ob_claimed_read", cpu_rdata, 8'h5C);
        @(negedge clk);
        cpu_addr = 16'h4020;
        src_en   = 4'b0000;
        ram_drv  = 8'h11;
        #1;
`ifdef CPU_BUS_OPEN_BUS_EN
        check("ob_window_read", cpu_rdata, 8'h5C);
`else
        check("ob_window_read", cpu_rdata, 8'h11);
`endif
        @(negedge clk);
        cpu_read = 0;

        run_dma(8'h02, 1'b0, 1'b1, 0);
        run_dma(8'h02, 1'b1, 1'b0, 0);
        run_dma(8'h02, 1'b0, 1'b0, 100);
        run_dma(8'h03, 1'b1, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
